// File: rtl/legv8_mc_control.sv
// rtl/legv8_mc_control.sv - multicycle LEGv8 control FSM with memory handshake, trap and retire counter
module legv8_mc_control #(
  parameter bit EN_IMM = 1'b1,
  parameter bit EN_EXC = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      Op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic [1:0]       ALUOp,
  output logic             Exc,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_EXC    = 4'd9
  } state_t;

  state_t state_q, state_d;
  logic   is_ldur, is_stur, is_cbz, is_r, is_imm;
  logic   ir_w, pc_w, reg_w, mem_w, exc_p, retire;

  assign is_ldur = (Op == 11'b111_1100_0010);
  assign is_stur = (Op == 11'b111_1100_0000);
  assign is_cbz  = (Op[10:3] == 8'b1011_0100);
  assign is_r    = (Op == 11'b100_0101_1000) || (Op == 11'b110_0101_1000) ||
                   (Op == 11'b100_0101_0000) || (Op == 11'b101_0101_0000);
  assign is_imm  = EN_IMM && ((Op[10:1] == 10'b100_1000_100) ||
                              (Op[10:1] == 10'b110_1000_100));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = S_FETCH;
    ir_w     = 1'b0;
    pc_w     = 1'b0;
    PCSrc    = 2'b00;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    reg_w    = 1'b0;
    MemRead  = 1'b0;
    mem_w    = 1'b0;
    Branch   = 1'b0;
    ALUOp    = 2'b00;
    exc_p    = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ir_w    = mem_ready;
        pc_w    = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        Reg2Loc = is_stur | is_cbz;
        if (is_ldur || is_stur)  state_d = S_MEMADR;
        else if (is_r || is_imm) state_d = S_EXEC;
        else if (is_cbz)         state_d = S_BRANCH;
        else                     state_d = EN_EXC ? S_EXC : S_FETCH;
      end
      S_MEMADR: begin
        ALUSrc  = 1'b1;
        state_d = is_ldur ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        ALUSrc  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_w    = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        mem_w   = 1'b1;
        Reg2Loc = 1'b1;
        ALUSrc  = 1'b1;
        retire  = mem_ready;
        state_d = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC, S_ALUWB: begin
        // write-back repeats the execute decode so the ALU result stays valid
        if (is_r) begin
          ALUOp = 2'b10;
        end else if (is_imm) begin
          ALUOp  = 2'b11;
          ALUSrc = 1'b1;
        end
        if (state_q == S_ALUWB) begin
          reg_w  = 1'b1;
          retire = 1'b1;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_BRANCH: begin
        Reg2Loc = 1'b1;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
        PCSrc   = 2'b01;
        pc_w    = Zero;
        retire  = 1'b1;
      end
      S_EXC: begin
        exc_p = 1'b1;
        pc_w  = 1'b1;
        PCSrc = 2'b10;
      end
      default: ;
    endcase
  end

  // architectural writes are suppressed for the whole time reset is held low
  assign IRWrite  = ir_w  & reset;
  assign PCWrite  = pc_w  & reset;
  assign RegWrite = reg_w & reset;
  assign MemWrite = mem_w & reset;
  assign Exc      = exc_p & reset;
  assign state    = state_q;

endmodule

// File: tb/tb_legv8_mc_control.sv
// tb/tb_legv8_mc_control.sv - self-checking bench for legv8_mc_control
module tb_legv8_mc_control;
  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
  localparam logic [10:0] OP_CBZ  = 11'b101_1010_0101;
  localparam logic [10:0] OP_SUBI = 11'b110_1000_1000;
  localparam int C_LD = 0, C_ST = 1, C_R = 2, C_IMM = 3, C_CBZ = 4, C_UND = 5;

  logic clk = 1'b0, reset = 1'b1, Zero = 1'b0, mem_ready = 1'b0;
  logic [10:0] Op = '0;
  int checks = 0, errors = 0;

  logic a_IRWrite, a_PCWrite, a_Reg2Loc, a_ALUSrc, a_MemtoReg, a_RegWrite;
  logic a_MemRead, a_MemWrite, a_Branch, a_Exc;
  logic [1:0] a_PCSrc, a_ALUOp;
  logic [3:0] a_state;
  logic [15:0] a_retired;
  logic b_IRWrite, b_PCWrite, b_Reg2Loc, b_ALUSrc, b_MemtoReg, b_RegWrite;
  logic b_MemRead, b_MemWrite, b_Branch, b_Exc;
  logic [1:0] b_PCSrc, b_ALUOp;
  logic [3:0] b_state;
  logic [1:0] b_retired;

  legv8_mc_control dut_a (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .IRWrite(a_IRWrite), .PCWrite(a_PCWrite), .PCSrc(a_PCSrc), .Reg2Loc(a_Reg2Loc),
    .ALUSrc(a_ALUSrc), .MemtoReg(a_MemtoReg), .RegWrite(a_RegWrite), .MemRead(a_MemRead),
    .MemWrite(a_MemWrite), .Branch(a_Branch), .ALUOp(a_ALUOp), .Exc(a_Exc),
    .state(a_state), .retired(a_retired)
  );

  legv8_mc_control #(.EN_IMM(1'b0), .EN_EXC(1'b1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .IRWrite(b_IRWrite), .PCWrite(b_PCWrite), .PCSrc(b_PCSrc), .Reg2Loc(b_Reg2Loc),
    .ALUSrc(b_ALUSrc), .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite), .MemRead(b_MemRead),
    .MemWrite(b_MemWrite), .Branch(b_Branch), .ALUOp(b_ALUOp), .Exc(b_Exc),
    .state(b_state), .retired(b_retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc(input logic [10:0] op, input logic mr, input logic z);
    @(negedge clk);
    Op = op; mem_ready = mr; Zero = z;
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  function automatic int classify(input logic [10:0] op);
    if (op == OP_LDUR) return C_LD;
    if (op == OP_STUR) return C_ST;
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return C_R;
    if (op[10:1] == 10'b100_1000_100 || op[10:1] == 10'b110_1000_100) return C_IMM;
    if (op[10:3] == 8'b1011_0100) return C_CBZ;
    return C_UND;
  endfunction

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1; Op = OP_LDUR;
    #1;
    checks++; if (a_IRWrite !== 1'b0 || a_PCWrite !== 1'b0) begin errors++;
      $display("FAIL reset_gate got IRWrite=%b PCWrite=%b want 0 0", a_IRWrite, a_PCWrite); end
    @(posedge clk); #1;
    checks++; if (a_state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", a_state); end
    checks++; if (a_retired !== 16'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", a_retired); end
    checks++; if (a_MemRead !== 1'b1 || a_IRWrite !== 1'b0) begin errors++;
      $display("FAIL reset_fetch got MemRead=%b IRWrite=%b want 1 0", a_MemRead, a_IRWrite); end
    reset = 1'b1; #1;
    checks++; if (a_IRWrite !== 1'b1 || a_PCWrite !== 1'b1 || a_PCSrc !== 2'b00) begin errors++;
      $display("FAIL fetch_load got IRWrite=%b PCWrite=%b PCSrc=%b want 1 1 00", a_IRWrite, a_PCWrite, a_PCSrc); end
  endtask

  task automatic test_ldur_wait;
    int   st[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
    logic mr[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(OP_LDUR, mr[i], 1'b0);
      checks++; if (a_state !== 4'(st[i])) begin errors++;
        $display("FAIL ldur_state[%0d] got %0d want %0d", i, a_state, st[i]); end
      checks++; if (a_RegWrite !== (st[i] == 4) || a_MemtoReg !== (st[i] == 4)) begin errors++;
        $display("FAIL ldur_wb[%0d] got RegWrite=%b MemtoReg=%b in state %0d", i, a_RegWrite, a_MemtoReg, st[i]); end
    end
    checks++; if (a_retired !== 16'd1) begin errors++; $display("FAIL ldur_retired got %0d want 1", a_retired); end
  endtask

  task automatic test_stur_add;
    int st[9] = '{0, 1, 2, 5, 0, 1, 6, 7, 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc((i < 4) ? OP_STUR : OP_ADD, 1'b1, 1'b0);
      checks++; if (a_state !== 4'(st[i])) begin errors++;
        $display("FAIL stur_add_state[%0d] got %0d want %0d", i, a_state, st[i]); end
      if (st[i] == 5) begin
        checks++; if (a_MemWrite !== 1'b1 || a_Reg2Loc !== 1'b1) begin errors++;
          $display("FAIL stur_memwr got MemWrite=%b Reg2Loc=%b want 1 1", a_MemWrite, a_Reg2Loc); end
      end
      if (st[i] == 7) begin
        checks++; if (a_RegWrite !== 1'b1 || a_ALUOp !== 2'b10) begin errors++;
          $display("FAIL add_aluwb got RegWrite=%b ALUOp=%b want 1 10", a_RegWrite, a_ALUOp); end
      end
    end
    checks++; if (a_retired !== 16'd2) begin errors++; $display("FAIL stur_add_retired got %0d want 2", a_retired); end
  endtask

  task automatic test_cbz;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      logic z;
      z = (k == 0);
      cyc(OP_CBZ, 1'b1, ~z);
      cyc(OP_CBZ, 1'b1, ~z);
      cyc(OP_CBZ, 1'b1, z);
      checks++; if (a_state !== 4'd8 || a_Branch !== 1'b1 || a_PCSrc !== 2'b01) begin errors++;
        $display("FAIL cbz_branch[%0d] got state=%0d Branch=%b PCSrc=%b want 8 1 01", k, a_state, a_Branch, a_PCSrc); end
      checks++; if (a_PCWrite !== z) begin errors++;
        $display("FAIL cbz_pcwrite[%0d] got %b want %b", k, a_PCWrite, z); end
    end
    cyc(OP_CBZ, 1'b0, 1'b0);
    checks++; if (a_state !== 4'd0 || a_retired !== 16'd2) begin errors++;
      $display("FAIL cbz_retired got state=%0d retired=%0d want 0 2", a_state, a_retired); end
  endtask

  task automatic test_exc;
    do_reset();
    cyc(11'd0, 1'b1, 1'b0);
    cyc(11'd0, 1'b1, 1'b0);
    checks++; if (a_state !== 4'd1) begin errors++; $display("FAIL exc_decode got %0d want 1", a_state); end
    cyc(11'd0, 1'b0, 1'b0);
    checks++; if (a_state !== 4'd9 || a_Exc !== 1'b1 || a_PCWrite !== 1'b1 || a_PCSrc !== 2'b10) begin errors++;
      $display("FAIL exc_trap got state=%0d Exc=%b PCWrite=%b PCSrc=%b want 9 1 1 10", a_state, a_Exc, a_PCWrite, a_PCSrc); end
    cyc(11'd0, 1'b0, 1'b0);
    checks++; if (a_state !== 4'd0 || a_retired !== 16'd0) begin errors++;
      $display("FAIL exc_retired got state=%0d retired=%0d want 0 0", a_state, a_retired); end
  endtask

  task automatic test_imm;
    do_reset();
    cyc(OP_SUBI, 1'b1, 1'b0);
    cyc(OP_SUBI, 1'b1, 1'b0);
    cyc(OP_SUBI, 1'b1, 1'b0);
    checks++; if (a_state !== 4'd6 || a_ALUOp !== 2'b11 || a_ALUSrc !== 1'b1) begin errors++;
      $display("FAIL subi_exec got state=%0d ALUOp=%b ALUSrc=%b want 6 11 1", a_state, a_ALUOp, a_ALUSrc); end
    checks++; if (b_state !== 4'd9 || b_Exc !== 1'b1) begin errors++;
      $display("FAIL subi_noimm got state=%0d Exc=%b want 9 1", b_state, b_Exc); end
    cyc(OP_SUBI, 1'b0, 1'b0);
    checks++; if (a_state !== 4'd7 || a_RegWrite !== 1'b1 || a_ALUOp !== 2'b11) begin errors++;
      $display("FAIL subi_aluwb got state=%0d RegWrite=%b ALUOp=%b want 7 1 11", a_state, a_RegWrite, a_ALUOp); end
    checks++; if (b_state !== 4'd0 || b_retired !== 2'd0) begin errors++;
      $display("FAIL subi_noimm_ret got state=%0d retired=%0d want 0 0", b_state, b_retired); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < 4; i++) cyc(OP_ADD, 1'b1, 1'b0);
    cyc(OP_STUR, 1'b1, 1'b0);
    cyc(OP_STUR, 1'b1, 1'b0);
    cyc(OP_STUR, 1'b1, 1'b0);
    cyc(OP_STUR, 1'b0, 1'b0);
    checks++; if (a_state !== 4'd5 || a_MemWrite !== 1'b1 || a_retired !== 16'd1) begin errors++;
      $display("FAIL mid_memwr got state=%0d MemWrite=%b retired=%0d want 5 1 1", a_state, a_MemWrite, a_retired); end
    cyc(OP_STUR, 1'b0, 1'b0);
    reset = 1'b0; #1;
    checks++; if (a_MemWrite !== 1'b0) begin errors++; $display("FAIL mid_drop got MemWrite=%b want 0", a_MemWrite); end
    @(posedge clk); #1;
    checks++; if (a_state !== 4'd0 || a_retired !== 16'd0) begin errors++;
      $display("FAIL mid_reset got state=%0d retired=%0d want 0 0", a_state, a_retired); end
    reset = 1'b1;
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 0; i < 20; i++) cyc(OP_ORR, 1'b1, 1'b0);
    cyc(OP_ORR, 1'b0, 1'b0);
    checks++; if (b_retired !== 2'd1) begin errors++; $display("FAIL wrap_b got %0d want 1", b_retired); end
    checks++; if (a_retired !== 16'd5) begin errors++; $display("FAIL wrap_a got %0d want 5", a_retired); end
  endtask

  task automatic test_random;
    int st_q[$];
    logic mr_q[$];
    logic [10:0] r_ops[4] = '{OP_ADD, OP_SUB, OP_AND, OP_ORR};
    logic [10:0] op;
    int cls, exp_ret, st;
    logic z;
    exp_ret = 0;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      cls = int'($urandom_range(0, 5));
      case (cls)
        C_LD:    op = OP_LDUR;
        C_ST:    op = OP_STUR;
        C_R:     op = r_ops[$urandom_range(0, 3)];
        C_IMM:   op = {($urandom_range(0, 1) != 0) ? 10'b110_1000_100 : 10'b100_1000_100, 1'($urandom)};
        C_CBZ:   op = {8'b1011_0100, 3'($urandom)};
        default: begin
          op = 11'($urandom);
          while (classify(op) != C_UND) op = 11'($urandom);
        end
      endcase
      st_q.delete(); mr_q.delete();
      repeat ($urandom_range(0, 2)) begin st_q.push_back(0); mr_q.push_back(1'b0); end
      st_q.push_back(0); mr_q.push_back(1'b1);
      st_q.push_back(1); mr_q.push_back(1'($urandom));
      case (cls)
        C_LD: begin
          st_q.push_back(2); mr_q.push_back(1'($urandom));
          repeat ($urandom_range(0, 2)) begin st_q.push_back(3); mr_q.push_back(1'b0); end
          st_q.push_back(3); mr_q.push_back(1'b1);
          st_q.push_back(4); mr_q.push_back(1'($urandom));
        end
        C_ST: begin
          st_q.push_back(2); mr_q.push_back(1'($urandom));
          repeat ($urandom_range(0, 2)) begin st_q.push_back(5); mr_q.push_back(1'b0); end
          st_q.push_back(5); mr_q.push_back(1'b1);
        end
        C_R, C_IMM: begin
          st_q.push_back(6); mr_q.push_back(1'($urandom));
          st_q.push_back(7); mr_q.push_back(1'($urandom));
        end
        C_CBZ:   begin st_q.push_back(8); mr_q.push_back(1'($urandom)); end
        default: begin st_q.push_back(9); mr_q.push_back(1'($urandom)); end
      endcase
      for (int i = 0; i < st_q.size(); i++) begin
        st = st_q[i];
        z  = 1'($urandom);
        cyc(op, mr_q[i], z);
        if (i == 0) begin
          checks++; if (a_retired !== 16'(exp_ret)) begin errors++;
            $display("FAIL rnd_retired[%0d] got %0d want %0d", n, a_retired, exp_ret); end
        end
        checks++; if (a_state !== 4'(st)) begin errors++;
          $display("FAIL rnd_state[%0d.%0d] op=%b got %0d want %0d", n, i, op, a_state, st); end
        checks++; if (a_MemWrite !== (st == 5) || a_RegWrite !== (st == 4 || st == 7) || a_Exc !== (st == 9)) begin errors++;
          $display("FAIL rnd_writes[%0d.%0d] got MemWrite=%b RegWrite=%b Exc=%b in state %0d", n, i, a_MemWrite, a_RegWrite, a_Exc, st); end
        checks++; if (a_IRWrite !== (st == 0 && mr_q[i]) ||
                      a_PCWrite !== ((st == 0 && mr_q[i]) || (st == 8 && z) || st == 9)) begin errors++;
          $display("FAIL rnd_loads[%0d.%0d] got IRWrite=%b PCWrite=%b in state %0d", n, i, a_IRWrite, a_PCWrite, st); end
      end
      if (cls != C_UND) exp_ret++;
    end
    cyc(OP_ADD, 1'b0, 1'b0);
    checks++; if (a_state !== 4'd0 || a_retired !== 16'(exp_ret)) begin errors++;
      $display("FAIL rnd_final got state=%0d retired=%0d want 0 %0d", a_state, a_retired, exp_ret); end
  endtask

  initial begin
    test_reset();
    test_ldur_wait();
    test_stur_add();
    test_cbz();
    test_exc();
    test_imm();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
